mul64_div32_seq: RTL and testbench

Sequential unsigned divider: a 64-bit dividend divided by a 32-bit divisor gives a 32-bit quotient and a 32-bit remainder.
- It is the inverse partner of the 32x32 multiplier datapath. Its dividend port takes the multiplier's `{high_result, low_result}` word and its divisor port takes one multiplier operand, so the result recovers the other operand (round-trip check, modular reduction).
- It uses a single-request valid/ready handshake on input and output, and a restoring shift-subtract core that produces one quotient bit per cycle (two with the configuration macro).

---
 rtl/mul64_div32_seq.sv | 91 +++++++++
 tb/tb_mul64_div32_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul64_div32_seq.sv
// mul64_div32_seq: restoring 64/32 unsigned divider with valid/ready handshake; MUL64_DIV32_RADIX4_EN retires two quotient bits per cycle
module mul64_div32_seq #(
    parameter int    UUID = 0,
    parameter string NAME = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [63:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero,
    output logic        o_overflow
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
`ifdef MUL64_DIV32_RADIX4_EN
    localparam logic [4:0] CNT_INIT = 5'd15;
`else
    localparam logic [4:0] CNT_INIT = 5'd31;
`endif
    logic [1:0]  state;
    logic [31:0] rem, lo, div;
    logic [4:0]  cnt;
    logic [63:0] one, nxt;
    // {rem, lo} shifts left as a pair; quotient bits enter at the bottom of lo
    function automatic logic [63:0] step(input logic [63:0] rl, input logic [31:0] d);
        logic [32:0] df;
        df = rl[63:31] - {1'b0, d};
        return df[32] ? {rl[62:0], 1'b0} : {df[31:0], rl[30:0], 1'b1};
    endfunction
    always_comb begin
        one = step({rem, lo}, div);
`ifdef MUL64_DIV32_RADIX4_EN
        nxt = step(one, div);
`else
        nxt = one;
`endif
    end
    assign i_ready = state == IDLE;
    assign o_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rem           <= '0;
            lo            <= '0;
            div           <= '0;
            cnt           <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    div <= i_divisor;
                    rem <= i_dividend[63:32];
                    lo  <= i_dividend[31:0];
                    cnt <= CNT_INIT;
                    if (i_divisor == 32'd0 || i_dividend[63:32] >= i_divisor) begin
                        state         <= DONE;
                        o_quotient    <= '1;
                        o_remainder   <= i_dividend[31:0];
                        o_div_by_zero <= i_divisor == 32'd0;
                        o_overflow    <= i_divisor != 32'd0;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    {rem, lo} <= nxt;
                    cnt       <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state       <= DONE;
                        o_quotient  <= nxt[31:0];
                        o_remainder <= nxt[63:32];
                    end
                end
                DONE: if (o_ready) begin
                    state         <= IDLE;
                    o_div_by_zero <= 1'b0;
                    o_overflow    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul64_div32_seq.sv
// tb_mul64_div32_seq: directed and random checks of mul64_div32_seq against an arithmetic reference model
module tb_mul64_div32_seq;
`ifdef MUL64_DIV32_RADIX4_EN
    localparam int NLAT = 17;
`else
    localparam int NLAT = 33;
`endif
    logic        clk = 0, rst = 1, i_valid = 0, o_ready = 0;
    logic        i_ready, o_valid, o_div_by_zero, o_overflow;
    logic [63:0] i_dividend = '0;
    logic [31:0] i_divisor = '0, o_quotient, o_remainder;
    int total = 0, bad = 0;

    mul64_div32_seq dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid), .o_ready(o_ready),
        .o_quotient(o_quotient), .o_remainder(o_remainder),
        .o_div_by_zero(o_div_by_zero), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void ref_div(input logic [63:0] x, input logic [31:0] d,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov, output int lat);
        logic [63:0] qq, rr;
        dz = d == 0;
        ov = !dz && x[63:32] >= d;
        qq = dz ? 64'd0 : x / {32'd0, d};
        rr = dz ? 64'd0 : x % {32'd0, d};
        q = (dz || ov) ? 32'hFFFF_FFFF : qq[31:0];
        r = (dz || ov) ? x[31:0] : rr[31:0];
        lat = (dz || ov) ? 1 : NLAT;
    endfunction

    // Model state: pend = a request is in flight, k = edges since the accept edge
    logic        pend = 0, edz = 0, eov = 0;
    logic [31:0] eq = 0, er = 0, hq = 0, hr = 0;
    int          k = 0, lat = 0;
    always @(negedge clk) begin
        logic ev;
        ev = pend && k >= lat - 1;
        chk("i_ready", i_ready, !pend);
        chk("o_valid", o_valid, ev);
        chk("quotient", o_quotient, ev ? eq : hq);
        chk("remainder", o_remainder, ev ? er : hr);
        chk("div_by_zero", o_div_by_zero, ev && edz);
        chk("overflow", o_overflow, ev && eov);
        if (rst) begin
            pend = 0; hq = 0; hr = 0;
        end else if (pend) begin
            if (ev && o_ready) begin
                pend = 0; hq = eq; hr = er;
            end else k++;
        end else if (i_valid) begin
            ref_div(i_dividend, i_divisor, eq, er, edz, eov, lat);
            pend = 1; k = 0;
        end
    end

    task automatic send(input logic [63:0] x, input logic [31:0] d);
        int n = 0;
        i_valid = 1; i_dividend = x; i_divisor = d;
        while (!i_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n == 100) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        i_valid = 0; i_dividend = {$urandom, $urandom}; i_divisor = $urandom;
    endtask

    task automatic expect_res(input logic [31:0] q, input logic [31:0] r, input logic dz,
                              input logic ov, input int el, input int hold);
        int n = 0;
        o_ready = 0;
        while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("latency", n + 1, el);
        chk("lit_quot", o_quotient, q);
        chk("lit_rem", o_remainder, r);
        chk("lit_dz", o_div_by_zero, dz);
        chk("lit_ov", o_overflow, ov);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_ready", i_ready, 0);
            chk("hold_quot", o_quotient, q);
        end
        o_ready = 1;
        @(posedge clk); #1;
        o_ready = 0;
        chk("post_ready", i_ready, 1);
    endtask

    initial begin
        logic [31:0] mq, mr, d, hi;
        logic mdz, mov, done;
        int ml, sel, n;
        ref_div(64'd100, 32'd7, mq, mr, mdz, mov, ml);
        chk("model_q", mq, 14);
        chk("model_r", mr, 2);
        ref_div(64'h5_0000_0009, 32'd0, mq, mr, mdz, mov, ml);
        chk("model_dz", {mdz, mov, mr}, {2'b10, 32'd9});
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", i_ready, 1);
        chk("rst_valid", o_valid, 0);
        send(64'd100, 32'd7);                 expect_res(32'd14, 32'd2, 0, 0, NLAT, 0);
        send(64'hFFFF_FFFE_0000_0001, '1);   expect_res('1, 32'd0, 0, 0, NLAT, 0);
        send(64'h0000_0001_0000_0000, 32'd2); expect_res(32'h8000_0000, 32'd0, 0, 0, NLAT, 0);
        send(64'h5_0000_0009, 32'd0);         expect_res('1, 32'd9, 1, 0, 1, 0);
        send(64'h3_0000_0000, 32'd3);         expect_res('1, 32'd0, 0, 1, 1, 0);
        send(64'd1000, 32'd33);               expect_res(32'd30, 32'd10, 0, 0, NLAT, 10);
        send(64'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", i_ready, 1);
        chk("midrst_out", {o_quotient, o_remainder}, 64'd0);
        rst = 0;
        send(64'd100, 32'd7);                 expect_res(32'd14, 32'd2, 0, 0, NLAT, 0);
        for (int t = 0; t < 200; t++) begin
            sel = $urandom % 8;
            d = sel == 0 ? 32'd0 : sel == 1 ? $urandom % 16 + 1 : sel == 2 ? 32'hFFFF_FFFF - $urandom % 4 : $urandom;
            hi = (sel == 7 || d == 0) ? $urandom : $urandom % d;
            repeat ($urandom % 3) begin @(posedge clk); #1; end
            send({hi, $urandom}, d);
            n = 0; done = 0;
            while (!done && n < 200) begin
                o_ready = $urandom % 2;
                done = o_valid && o_ready;
                @(posedge clk); #1;
                n++;
            end
            o_ready = 0;
            if (!done) chk("result_timeout", 0, 1);
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
